// File: rtl/eth_frame_parser_if.sv
// Byte-stream bundle between pcap replay, the frame parser and the payload consumer.
// Holds both the upstream packet bus (with its pause) and the downstream payload handshake.
interface eth_frame_parser_if;
   logic       in_avail;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_newpkt;
   logic       pause;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;

   modport master (
      output in_avail, in_valid, in_data, in_newpkt, out_ready,
      input  pause, out_valid, out_data, out_sop, out_eop
   );

   modport slave (
      input  in_avail, in_valid, in_data, in_newpkt, out_ready,
      output pause, out_valid, out_data, out_sop, out_eop
   );
endinterface

// File: rtl/eth_frame_parser.sv
// Ethernet frame parser: splits pcap-replay bytes into header fields and a buffered
// payload stream with SOP/EOP, throttling upstream via a registered pause.
module eth_frame_parser #(
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned PAUSE_THRESH = 5
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   eth_frame_parser_if.slave bus,
   output logic              hdr_valid,
   output logic [47:0]       dst_mac,
   output logic [47:0]       src_mac,
   output logic [15:0]       ethertype,
   output logic              vlan_present,
   output logic [15:0]       vlan_tci,
   output logic [15:0]       pkt_count,
   output logic [7:0]        runt_count,
   output logic              overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FillMax  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] PauseLvl = (AW+1)'(PAUSE_THRESH);

   typedef enum logic [1:0] {StIdle, StHdr, StVlan, StPayload} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        first_q, first_d;
   logic        avail_q;

   logic        accept, last;
   logic        hdr_done, runt_inc, clr_vlan, set_vlan, push_req;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   fill_q;
   logic          full, pop, push;
   logic [9:0]    head;

   // The last byte of a frame arrives with avail already dropped.
   assign accept = bus.in_valid && !bus.in_newpkt && (bus.in_avail || avail_q);
   assign last   = accept && !bus.in_avail && avail_q;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
         idx_q   <= '0;
         first_q <= 1'b0;
         avail_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         first_q <= first_d;
         avail_q <= bus.in_avail;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      first_d  = first_q;
      hdr_done = 1'b0;
      runt_inc = 1'b0;
      clr_vlan = 1'b0;
      set_vlan = 1'b0;
      push_req = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_newpkt) begin
               state_d  = StHdr;
               idx_d    = '0;
               clr_vlan = 1'b1;
            end
         end
         StHdr: begin
            if (bus.in_newpkt) begin
               // newpkt may be held for several cycles; only a started header is a runt
               runt_inc = (idx_q != 4'd0);
               idx_d    = '0;
               clr_vlan = 1'b1;
            end else if (accept) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd13) begin
                  if ({ethertype[7:0], bus.in_data} == 16'h8100) begin
                     if (last) begin
                        runt_inc = 1'b1;
                        state_d  = StIdle;
                     end else begin
                        state_d = StVlan;
                        idx_d   = '0;
                     end
                  end else begin
                     hdr_done = 1'b1;
                     first_d  = 1'b1;
                     state_d  = last ? StIdle : StPayload;
                  end
               end else if (last) begin
                  runt_inc = 1'b1;
                  state_d  = StIdle;
               end
            end
         end
         StVlan: begin
            if (bus.in_newpkt) begin
               runt_inc = 1'b1;
               state_d  = StHdr;
               idx_d    = '0;
               clr_vlan = 1'b1;
            end else if (accept) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd3) begin
                  hdr_done = 1'b1;
                  set_vlan = 1'b1;
                  first_d  = 1'b1;
                  state_d  = last ? StIdle : StPayload;
               end else if (last) begin
                  runt_inc = 1'b1;
                  state_d  = StIdle;
               end
            end
         end
         StPayload: begin
            if (bus.in_newpkt) begin
               state_d  = StHdr;
               idx_d    = '0;
               clr_vlan = 1'b1;
            end else if (accept) begin
               push_req = 1'b1;
               first_d  = 1'b0;
               if (last) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Header fields shift in MSB-first, so the first wire byte lands in the top byte.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         hdr_valid    <= 1'b0;
         dst_mac      <= '0;
         src_mac      <= '0;
         ethertype    <= '0;
         vlan_present <= 1'b0;
         vlan_tci     <= '0;
         pkt_count    <= '0;
         runt_count   <= '0;
      end else begin
         hdr_valid <= hdr_done;
         if (hdr_done) pkt_count <= pkt_count + 16'd1;
         if (runt_inc && runt_count != 8'hFF) runt_count <= runt_count + 8'd1;
         if (clr_vlan) begin
            vlan_present <= 1'b0;
            vlan_tci     <= '0;
         end
         if (set_vlan) vlan_present <= 1'b1;
         if (accept && state_q == StHdr) begin
            if (idx_q < 4'd6)       dst_mac   <= {dst_mac[39:0], bus.in_data};
            else if (idx_q < 4'd12) src_mac   <= {src_mac[39:0], bus.in_data};
            else                    ethertype <= {ethertype[7:0], bus.in_data};
         end
         if (accept && state_q == StVlan) begin
            if (idx_q < 4'd2) vlan_tci  <= {vlan_tci[7:0], bus.in_data};
            else              ethertype <= {ethertype[7:0], bus.in_data};
         end
      end
   end

   assign full = (fill_q == FillMax);
   assign pop  = bus.out_valid && bus.out_ready;
   // A push into a full FIFO only succeeds when a pop frees the slot in the same cycle.
   assign push = push_req && (!full || pop);
   assign head = mem[rd_ptr_q];

   always_ff @(posedge CLOCK) begin
      if (push) mem[wr_ptr_q] <= {last, first_q, bus.in_data};
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         overflow  <= 1'b0;
         bus.pause <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      fill_q <= fill_q + 1'b1;
         else if (!push && pop) fill_q <= fill_q - 1'b1;
         if (push_req && !push) overflow <= 1'b1;
         bus.pause <= (fill_q >= PauseLvl);
      end
   end

   // Head fields are gated so an empty FIFO presents all-zero outputs.
   assign bus.out_valid = (fill_q != '0);
   assign bus.out_data  = bus.out_valid ? head[7:0] : 8'h00;
   assign bus.out_sop   = bus.out_valid & head[8];
   assign bus.out_eop   = bus.out_valid & head[9];

endmodule

// File: tb/tb_eth_frame_parser.sv
// Scoreboard bench for eth_frame_parser: directed frames push expected headers and payload
// bytes; a negedge monitor pops and compares whatever the DUT presents.
module tb_eth_frame_parser;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] et;
      logic        vp;
      logic [15:0] tci;
   } hdr_t;

   logic        CLOCK;
   logic        RESET_N;
   logic        hdr_valid;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [15:0] ethertype;
   logic        vlan_present;
   logic [15:0] vlan_tci;
   logic [15:0] pkt_count;
   logic [7:0]  runt_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   hdr_t       hq [$];
   logic [9:0] pq [$];
   logic [7:0] frame [$];
   hdr_t       h;
   logic [9:0] p;
   bit         pause_seen;

   eth_frame_parser_if bus ();

   eth_frame_parser #(
      .FIFO_DEPTH  (8),
      .PAUSE_THRESH(5)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET_N     (RESET_N),
      .bus         (bus),
      .hdr_valid   (hdr_valid),
      .dst_mac     (dst_mac),
      .src_mac     (src_mac),
      .ethertype   (ethertype),
      .vlan_present(vlan_present),
      .vlan_tci    (vlan_tci),
      .pkt_count   (pkt_count),
      .runt_count  (runt_count),
      .overflow    (overflow)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   // Monitor: every header pulse and every payload handshake must match the scoreboard.
   always @(negedge CLOCK) begin
      if (RESET_N) begin
         if (bus.pause) pause_seen = 1'b1;
         if (hdr_valid) begin
            checks++;
            if (hq.size() == 0) begin
               errors++;
               $display("FAIL hdr_unexpected: got hdr_valid=1 required no header pulse");
            end else begin
               h = hq.pop_front();
               if ({dst_mac, src_mac, ethertype, vlan_present, vlan_tci} !==
                   {h.dst, h.src, h.et, h.vp, h.tci}) begin
                  errors++;
                  $display("FAIL hdr_fields: got %h %h %h %b %h required %h %h %h %b %h",
                           dst_mac, src_mac, ethertype, vlan_present, vlan_tci,
                           h.dst, h.src, h.et, h.vp, h.tci);
               end
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (pq.size() == 0) begin
               errors++;
               $display("FAIL payload_unexpected: got data=%h sop=%b eop=%b required none",
                        bus.out_data, bus.out_sop, bus.out_eop);
            end else begin
               p = pq.pop_front();
               if ({bus.out_eop, bus.out_sop, bus.out_data} !== p) begin
                  errors++;
                  $display("FAIL payload: got eop=%b sop=%b data=%h required eop=%b sop=%b data=%h",
                           bus.out_eop, bus.out_sop, bus.out_data, p[9], p[8], p[7:0]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                        input bit tag, input logic [15:0] tci, input logic [15:0] inner,
                        input int plen, input logic [7:0] base);
      frame.delete();
      for (int k = 5; k >= 0; k--) frame.push_back(dst[k*8 +: 8]);
      for (int k = 5; k >= 0; k--) frame.push_back(src[k*8 +: 8]);
      if (tag) begin
         frame.push_back(8'h81);
         frame.push_back(8'h00);
         frame.push_back(tci[15:8]);
         frame.push_back(tci[7:0]);
         frame.push_back(inner[15:8]);
         frame.push_back(inner[7:0]);
      end else begin
         frame.push_back(et[15:8]);
         frame.push_back(et[7:0]);
      end
      for (int k = 0; k < plen; k++) frame.push_back(base + 8'(k));
   endtask

   task automatic expect_hdr(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input logic vp, input logic [15:0] tci);
      hdr_t e;
      e.dst = dst; e.src = src; e.et = et; e.vp = vp; e.tci = tci;
      hq.push_back(e);
   endtask

   // Drive one frame; payload bytes at index >= hdr_len (first `keep` of them) are expected.
   task automatic send_frame(input int hdr_len, input bit honor, input int abort_at,
                             input int keep);
      int n;
      int w;
      bit aborted;
      n = frame.size();
      aborted = 1'b0;
      @(posedge CLOCK);
      #1;
      bus.in_newpkt = 1'b1;
      bus.in_avail  = 1'b1;
      bus.in_valid  = 1'b0;
      @(posedge CLOCK);
      for (int i = 0; i < n; i++) begin
         #1;
         bus.in_newpkt = 1'b0;
         w = 0;
         while (honor && bus.pause && w < 2000) begin
            bus.in_valid = 1'b0;
            @(posedge CLOCK);
            #1;
            w++;
         end
         if (w >= 2000) begin
            checks++;
            errors++;
            $display("FAIL pause_release: got pause stuck for %0d cycles required release", w);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = frame[i];
         bus.in_avail = (i != n - 1);
         if (!aborted && i >= hdr_len && (i - hdr_len) < keep)
            pq.push_back({1'(i == n - 1), 1'(i == hdr_len), frame[i]});
         @(posedge CLOCK);
         if (i == abort_at) begin
            #2;
            RESET_N = 1'b0;
            #1;
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data", 64'(bus.out_data), 64'd0);
            check("rst_pkt_count", 64'(pkt_count), 64'd0);
            check("rst_overflow", 64'(overflow), 64'd0);
            check("rst_dst_mac", 64'(dst_mac), 64'd0);
            check("rst_hdr_valid_pause", 64'({hdr_valid, bus.pause, bus.out_sop}), 64'd0);
            pq.delete();
            hq.delete();
            aborted = 1'b1;
            @(posedge CLOCK);
            #4;
            RESET_N = 1'b1;
            @(posedge CLOCK);
         end
      end
      #1;
      bus.in_valid = 1'b0;
      bus.in_avail = 1'b0;
   endtask

   task automatic drain();
      int c;
      c = 0;
      while ((pq.size() != 0 || hq.size() != 0) && c < 1000) begin
         @(posedge CLOCK);
         c++;
      end
      if (c >= 1000) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d hdr and %0d payload pending required 0", hq.size(), pq.size());
      end
      repeat (3) @(posedge CLOCK);
      #1;
   endtask

   initial begin
      RESET_N       = 1'b0;
      bus.in_avail  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_newpkt = 1'b0;
      bus.out_ready = 1'b1;
      pause_seen    = 1'b0;
      repeat (3) @(posedge CLOCK);
      #1;
      check("reset_counts", 64'({pkt_count, runt_count, overflow}), 64'd0);
      check("reset_stream", 64'({bus.out_valid, bus.pause, hdr_valid, vlan_present}), 64'd0);
      check("reset_ethertype", 64'(ethertype), 64'd0);
      @(negedge CLOCK);
      RESET_N = 1'b1;

      // 60-byte untagged frame
      build(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, 16'h0, 16'h0, 46, 8'h10);
      expect_hdr(48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0800, 1'b0, 16'h0000);
      send_frame(14, 1'b1, -1, 1000);
      drain();
      check("t1_pkt_count", 64'(pkt_count), 64'd1);
      check("t1_frame_len", 64'(frame.size()), 64'd60);

      // VLAN-tagged frame, then untagged frame clears the tag
      build(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h0, 1'b1, 16'h0064, 16'h86DD, 30, 8'hA0);
      expect_hdr(48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h86DD, 1'b1, 16'h0064);
      send_frame(18, 1'b1, -1, 1000);
      drain();
      check("t2_vlan_tci_held", 64'(vlan_tci), 64'h0064);
      build(48'h0200_0000_0001, 48'h00AA_BBCC_DDEE, 16'h0806, 1'b0, 16'h0, 16'h0, 6, 8'h40);
      expect_hdr(48'h0200_0000_0001, 48'h00AA_BBCC_DDEE, 16'h0806, 1'b0, 16'h0000);
      send_frame(14, 1'b1, -1, 1000);
      drain();
      check("t2_vlan_cleared", 64'(vlan_present), 64'd0);
      check("t2_pkt_count", 64'(pkt_count), 64'd3);

      // 10-byte runt, then a header-only 14-byte frame
      build(48'h1111_1111_1111, 48'h2222_2222_2222, 16'h0800, 1'b0, 16'h0, 16'h0, 0, 8'h00);
      while (frame.size() > 10) void'(frame.pop_back());
      send_frame(14, 1'b1, -1, 0);
      drain();
      check("t3_runt_count", 64'(runt_count), 64'd1);
      check("t3_pkt_unchanged", 64'(pkt_count), 64'd3);
      build(48'h3333_3333_3333, 48'h4444_4444_4444, 16'h88B5, 1'b0, 16'h0, 16'h0, 0, 8'h00);
      expect_hdr(48'h3333_3333_3333, 48'h4444_4444_4444, 16'h88B5, 1'b0, 16'h0000);
      send_frame(14, 1'b1, -1, 1000);
      drain();
      check("t3_hdr_only_pkt", 64'(pkt_count), 64'd4);
      check("t3_runt_still", 64'(runt_count), 64'd1);

      // Backpressure: stall the sink for 200+ cycles during a 100-byte payload
      build(48'h0000_0000_00AA, 48'h0000_0000_00BB, 16'h0800, 1'b0, 16'h0, 16'h0, 100, 8'h00);
      expect_hdr(48'h0000_0000_00AA, 48'h0000_0000_00BB, 16'h0800, 1'b0, 16'h0000);
      pause_seen = 1'b0;
      bus.out_ready = 1'b0;
      fork
         send_frame(14, 1'b1, -1, 1000);
         begin
            repeat (220) @(posedge CLOCK);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check("t4_pause_seen", 64'(pause_seen), 64'd1);
      check("t4_no_overflow", 64'(overflow), 64'd0);
      check("t4_pause_released", 64'(bus.pause), 64'd0);
      check("t4_pkt_count", 64'(pkt_count), 64'd5);

      // Overflow: ignore pause with a stalled sink; only the first 8 payload bytes survive
      build(48'h0000_0000_00CC, 48'h0000_0000_00DD, 16'h0800, 1'b0, 16'h0, 16'h0, 20, 8'h70);
      expect_hdr(48'h0000_0000_00CC, 48'h0000_0000_00DD, 16'h0800, 1'b0, 16'h0000);
      bus.out_ready = 1'b0;
      send_frame(14, 1'b0, -1, 8);
      check("t5_overflow_set", 64'(overflow), 64'd1);
      bus.out_ready = 1'b1;
      drain();
      build(48'h0000_0000_00EE, 48'h0000_0000_00FF, 16'h0800, 1'b0, 16'h0, 16'h0, 4, 8'hC0);
      expect_hdr(48'h0000_0000_00EE, 48'h0000_0000_00FF, 16'h0800, 1'b0, 16'h0000);
      send_frame(14, 1'b1, -1, 1000);
      drain();
      check("t5_overflow_sticky", 64'(overflow), 64'd1);
      check("t5_pkt_count", 64'(pkt_count), 64'd7);

      // Reset mid-payload, then a clean frame
      build(48'h5555_5555_5555, 48'h6666_6666_6666, 16'h0800, 1'b0, 16'h0, 16'h0, 40, 8'h20);
      expect_hdr(48'h5555_5555_5555, 48'h6666_6666_6666, 16'h0800, 1'b0, 16'h0000);
      send_frame(14, 1'b1, 34, 1000);
      drain();
      check("t6_after_abort_pkt", 64'(pkt_count), 64'd0);
      build(48'h7777_7777_7777, 48'h8888_8888_8888, 16'h0800, 1'b0, 16'h0, 16'h0, 8, 8'h90);
      expect_hdr(48'h7777_7777_7777, 48'h8888_8888_8888, 16'h0800, 1'b0, 16'h0000);
      send_frame(14, 1'b1, -1, 1000);
      drain();
      check("t6_pkt_count", 64'(pkt_count), 64'd1);
      check("t6_overflow_cleared", 64'(overflow), 64'd0);
      check("t6_runt_cleared", 64'(runt_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_frame_parser.md
Name: eth_frame_parser

Overview:
- Consumes the single-byte packet bus produced by the pcap replay stage (available/datavalid/data/newpkt), and drives that stage's pause input for backpressure.
- Splits each Ethernet frame into header fields (destination MAC, source MAC, EtherType, optional 802.1Q tag) and a payload byte stream with SOP/EOP markers and ready/valid handshake.
- Sits between pcap replay and protocol decoders (IPv4/UDP) in network test benches.

Parameters:
- FIFO_DEPTH, 8, payload buffer entries; power of two, minimum 4.
- PAUSE_THRESH, 5, fill level at or above which pause is asserted; must be at most FIFO_DEPTH-2.

Ports:
- CLOCK  input  1  sole clock; all logic on rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- in_avail  input  1  upstream available.
- in_valid  input  1  upstream datavalid.
- in_data  input  8  upstream data byte.
- in_newpkt  input  1  upstream newpkt; high for the first cycle(s) of a packet.
- pause  output  1  backpressure to upstream; registered.
- hdr_valid  output  1  one-cycle pulse when header fields are final.
- dst_mac  output  48  destination MAC; first wire byte in bits [47:40].
- src_mac  output  48  source MAC, same byte ordering.
- ethertype  output  16  inner EtherType (after VLAN tag if present).
- vlan_present  output  1  frame carried 0x8100 tag.
- vlan_tci  output  16  tag control info; 0 if no tag.
- out_valid  output  1  payload byte available.
- out_ready  input  1  downstream accepts byte when out_valid && out_ready.
- out_data  output  8  payload byte.
- out_sop  output  1  first payload byte of frame.
- out_eop  output  1  last payload byte of frame.
- pkt_count  output  16  frames with complete header; wraps.
- runt_count  output  8  frames ending before header complete; saturates at 255.
- overflow  output  1  sticky; a payload byte was dropped because the FIFO was full.

Behaviour:
- Byte acceptance:
  - A byte is accepted when in_valid=1, in_newpkt=0, and (in_avail=1 or avail_q=1), where avail_q is in_avail registered.
  - The last byte of a frame is an accepted byte with in_avail=0 and avail_q=1.
  - in_valid asserted outside these conditions is stale and is ignored.
- Reset: all outputs, counters, flags and header registers go to 0; FIFO is emptied; FSM enters IDLE.
- FSM:
  - IDLE: ignore bytes. On in_newpkt=1, go to HDR with idx=0.
  - HDR: accepted bytes 0-5 load dst_mac, 6-11 load src_mac, 12-13 load ethertype. After byte 13:
    - if ethertype==16'h8100, go to VLAN (idx=0);
    - otherwise pulse hdr_valid on the next cycle, increment pkt_count, go to PAYLOAD.
  - VLAN: bytes 0-1 load vlan_tci; bytes 2-3 overwrite ethertype. After byte 3, set vlan_present=1, pulse hdr_valid, increment pkt_count, go to PAYLOAD.
  - PAYLOAD: each accepted byte is written to the FIFO tagged with sop (first payload byte) and eop (last byte). After the last byte, go to IDLE.
  - Last byte seen in HDR or VLAN before the header completes: increment runt_count (saturating), no hdr_valid, go to IDLE.
  - Last byte coinciding with header completion: hdr_valid pulses, no payload emitted.
  - in_newpkt=1 in any non-IDLE state (frame truncated without a last byte): count as runt if still in HDR/VLAN; if in PAYLOAD, drop the unfinished frame's EOP silently. Restart HDR with idx=0.
- Header outputs: held from the hdr_valid pulse until overwritten by the next frame. vlan_present and vlan_tci clear on entry to HDR.
- FIFO:
  - Width 10 (data, sop, eop), depth FIFO_DEPTH.
  - out_* driven from the head entry; pop on out_valid && out_ready.
  - Simultaneous push and pop at full is allowed, with no drop.
  - Push while full and no pop: byte discarded, overflow set (sticky until reset).
  - Read and write pointers wrap modulo FIFO_DEPTH; fill count is one bit wider than the pointers.
- Pause: registered; pause <= (fill >= PAUSE_THRESH). This covers the two-cycle upstream reaction (pause sampled, then datavalid drops).
- Latency: payload byte accepted in cycle N appears on out_data in cycle N+1 when the FIFO was empty.

Test Plan:
- 60-byte untagged frame, dst FF:FF:FF:FF:FF:FF, src 00:11:22:33:44:55, type 0800, out_ready=1 -> hdr_valid single pulse with those fields; 46 payload bytes; out_sop on first, out_eop on 46th; pkt_count=1.
- Tagged frame: type 8100, TCI 0064, inner 86DD, 30 payload bytes -> vlan_present=1, vlan_tci=16'h0064, ethertype=16'h86DD, 30 bytes out; next untagged frame clears vlan_present.
- 10-byte frame -> runt_count=1, no hdr_valid, no out_valid. 14-byte frame -> hdr_valid pulse, zero payload bytes.
- out_ready=0 for 200 cycles during a 100-byte payload -> pause high once fill>=5, upstream holds; no byte lost; overflow=0; byte order preserved on release.
- Force pushes into full FIFO with pause ignored -> overflow=1, stays 1 until RESET_N.
- RESET_N low mid-payload -> all outputs 0 within same cycle; remainder of frame ignored; next frame parsed correctly, pkt_count=1.
